pipe_stall_ctrl: RTL and testbench

PIPE_STALL_CTRL -- requirements
Module: pipe_stall_ctrl

---
 rtl/pipe_stall_ctrl.sv | 131 +++++++++++++
 tb/tb_pipe_stall_ctrl.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl.sv
// Pipeline stall/flush controller: freezes on memory wait, flushes after taken branches and
// inserts bubbles on ID hazards. Define STALL_PERF_EN to build the stall-cycle counter.
module pipe_stall_ctrl #(
  parameter int unsigned FLUSH_CYC = 2,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             br_stall,
  input  logic             br_taken,
  input  logic             mem_busy,
  input  logic             perf_clr,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned FcW = 3;
  localparam logic [FcW-1:0] FlushLoad = FcW'(FLUSH_CYC - 1);

  typedef enum logic [1:0] {StRun, StHaz, StFlush, StMwait} state_e;

  state_e         state_q, state_d;
  logic [FcW-1:0] fcnt_q, fcnt_d;

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    exmem_en   = 1'b1;

    if (rst) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_en    = 1'b0;
      idex_flush = 1'b1;
      exmem_en   = 1'b0;
      state_d    = StRun;
      fcnt_d     = '0;
    end else begin
      unique case (state_q)
        StRun, StHaz, StMwait: begin
          if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            state_d  = StMwait;
          end else if (br_taken) begin
            // The branch cycle itself is the first of the FLUSH_CYC flush cycles.
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
            fcnt_d     = FlushLoad;
            state_d    = (FLUSH_CYC > 1) ? StFlush : StRun;
          end else if (br_stall) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            idex_flush = 1'b1;
            state_d    = StHaz;
          end else begin
            state_d = StRun;
          end
        end
        StFlush: begin
          if (mem_busy) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
          end else begin
            // fcnt_q counts flush cycles still owed, this one included.
            ifid_flush = 1'b1;
            if (fcnt_q <= FcW'(1)) begin
              fcnt_d  = '0;
              state_d = StRun;
            end else begin
              fcnt_d = fcnt_q - FcW'(1);
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StRun;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end
  end

`ifdef STALL_PERF_EN
  logic [CNT_W-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = stall_q;
    if (perf_clr) begin
      stall_d = '0;
    end else if (!pc_en && (stall_q != {CNT_W{1'b1}})) begin
      stall_d = stall_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_q <= '0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign stall_cycles = stall_q;
`else
  logic unused_perf_clr;
  assign unused_perf_clr = perf_clr;
  assign stall_cycles    = '0;
`endif

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Self-checking bench for pipe_stall_ctrl: directed scenarios then random traffic, all checked
// against a cycle-level reference model of the stall/flush rules.
module tb_pipe_stall_ctrl;

  localparam int unsigned FlushCyc = 2;
  localparam int unsigned CntW     = 4;
  localparam int          CntMax   = (1 << CntW) - 1;

  logic            clk;
  logic            rst;
  logic            br_stall;
  logic            br_taken;
  logic            mem_busy;
  logic            perf_clr;
  logic            pc_en;
  logic            ifid_en;
  logic            ifid_flush;
  logic            idex_en;
  logic            idex_flush;
  logic            exmem_en;
  logic [CntW-1:0] stall_cycles;

  int tests  = 0;
  int failed = 0;
  int m_left = 0;  // flush cycles still owed after the branch cycle
  int m_cnt  = 0;  // cycles with pc_en low since reset/clear

  pipe_stall_ctrl #(
    .FLUSH_CYC(FlushCyc),
    .CNT_W    (CntW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .br_stall    (br_stall),
    .br_taken    (br_taken),
    .mem_busy    (mem_busy),
    .perf_clr    (perf_clr),
    .pc_en       (pc_en),
    .ifid_en     (ifid_en),
    .ifid_flush  (ifid_flush),
    .idex_en     (idex_en),
    .idex_flush  (idex_flush),
    .exmem_en    (exmem_en),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit order: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en}
  function automatic logic [5:0] model_outs(input logic r, input logic s, input logic t,
                                            input logic m, input int left);
    if (r)        return 6'b001010;
    if (m)        return 6'b000000;
    if (left > 0) return 6'b111101;
    if (t)        return 6'b111111;
    if (s)        return 6'b000111;
    return 6'b110101;
  endfunction

  task automatic step(input logic r, input logic s, input logic t, input logic m,
                      input logic c, input string tag);
    logic [5:0] exp_o;
    logic [5:0] got_o;
    int         exp_cnt;
    @(negedge clk);
    rst      = r;
    br_stall = s;
    br_taken = t;
    mem_busy = m;
    perf_clr = c;
    #1;
    exp_o = model_outs(r, s, t, m, m_left);
    got_o = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en};
`ifdef STALL_PERF_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 0;
`endif
    tests++;
    assert (got_o === exp_o)
    else begin
      failed++;
      $error("FAIL %s outputs {pc,ifen,iffl,idexen,idexfl,exmem}: got %b expected %b",
             tag, got_o, exp_o);
    end
    tests++;
    assert (stall_cycles === CntW'(exp_cnt))
    else begin
      failed++;
      $error("FAIL %s stall_cycles: got %0d expected %0d", tag, stall_cycles, exp_cnt);
    end
    @(posedge clk);
    if (r) begin
      m_left = 0;
      m_cnt  = 0;
    end else begin
      if (c) m_cnt = 0;
      else if (!exp_o[5] && m_cnt < CntMax) m_cnt++;
      if (!m) begin
        if (m_left > 0) m_left--;
        else if (t) m_left = FlushCyc - 1;
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    br_stall = 1'b0;
    br_taken = 1'b0;
    mem_busy = 1'b0;
    perf_clr = 1'b0;

    step(1, 0, 0, 0, 0, "reset0");
    step(1, 1, 1, 1, 1, "reset1");
    step(0, 0, 0, 0, 0, "post_reset");

    // Single hazard for two cycles.
    step(0, 1, 0, 0, 0, "haz1");
    step(0, 1, 0, 0, 0, "haz2");
    step(0, 0, 0, 0, 0, "haz_resume");
    step(0, 0, 0, 0, 0, "haz_idle");

    // Branch; stall in the second flush cycle must be ignored.
    step(0, 0, 1, 0, 0, "br_take");
    step(0, 1, 0, 0, 0, "br_flush2");
    step(0, 0, 0, 0, 0, "br_done");

    // Memory wait in the middle of a flush.
    step(0, 0, 1, 0, 0, "mw_take");
    step(0, 0, 0, 1, 0, "mw_busy1");
    step(0, 1, 1, 1, 0, "mw_busy2");
    step(0, 0, 0, 1, 0, "mw_busy3");
    step(0, 1, 0, 0, 0, "mw_flush");
    step(0, 0, 0, 0, 0, "mw_done");

    // Simultaneous requests: freeze first, then the branch.
    step(0, 1, 1, 1, 0, "sim_freeze");
    step(0, 1, 1, 0, 0, "sim_branch");
    step(0, 0, 0, 0, 0, "sim_flush");
    step(0, 0, 0, 0, 0, "sim_done");

    // Reset abandons MWAIT and FLUSH.
    step(0, 0, 0, 1, 0, "rst_mwait");
    step(1, 0, 0, 1, 0, "rst_in_mwait");
    step(0, 0, 0, 0, 0, "rst_mwait_after");
    step(0, 0, 1, 0, 0, "rst_take");
    step(1, 0, 0, 0, 0, "rst_in_flush");
    step(0, 0, 0, 0, 0, "rst_flush_after");

    // Saturation and clear-wins-over-increment.
    for (int i = 0; i < 20; i++) step(0, 1, 0, 0, 0, "sat_stall");
    step(0, 1, 0, 0, 1, "sat_clr");
    step(0, 0, 0, 0, 0, "sat_after_clr");

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(39) == 0), ($urandom_range(2) == 0), ($urandom_range(4) == 0),
           ($urandom_range(3) == 0), ($urandom_range(15) == 0), "random");
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
